// File: rtl/load_store_unit.sv
// Data-memory access stage: turns an ALU effective address plus rs2 into a
// req/ack bus transaction and returns extended load data with a done pulse.
module load_store_unit #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        is_store,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [31:0] rdata,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t      state;
    logic        is_store_q;
    logic [2:0]  funct3_q;
    logic [1:0]  off_q;
    logic [31:0] tcnt;

    logic        legal;
    logic [3:0]  be_c;
    logic [31:0] wrep_c;
    logic [31:0] lane;
    logic [31:0] ext_c;

    // funct3[1:0] selects the access width; funct3[2] is the unsigned flag,
    // which is only meaningful for byte/half loads.
    always_comb begin
        legal  = 1'b1;
        be_c   = '0;
        wrep_c = wdata;
        case (funct3[1:0])
            2'b00: begin
                be_c   = 4'b0001 << addr[1:0];
                wrep_c = {4{wdata[7:0]}};
            end
            2'b01: begin
                be_c   = 4'b0011 << addr[1:0];
                wrep_c = {2{wdata[15:0]}};
                if (addr[0]) legal = 1'b0;
            end
            2'b10: begin
                be_c = 4'b1111;
                if (addr[1:0] != 2'b00) legal = 1'b0;
            end
            default: begin
                be_c  = '0;
                legal = 1'b0;
            end
        endcase
        if (funct3[2] && (is_store || funct3[1])) legal = 1'b0;
    end

    always_comb begin
        lane = mem_rdata >> {off_q, 3'b000};
        case (funct3_q)
            3'b000:  ext_c = {{24{lane[7]}}, lane[7:0]};
            3'b001:  ext_c = {{16{lane[15]}}, lane[15:0]};
            3'b100:  ext_c = {24'd0, lane[7:0]};
            3'b101:  ext_c = {16'd0, lane[15:0]};
            default: ext_c = lane;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            is_store_q <= 1'b0;
            funct3_q   <= '0;
            off_q      <= '0;
            tcnt       <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
            rdata      <= '0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            mem_be     <= '0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        is_store_q <= is_store;
                        funct3_q   <= funct3;
                        off_q      <= addr[1:0];
                        busy       <= 1'b1;
                        if (legal) begin
                            state     <= ACCESS;
                            tcnt      <= '0;
                            mem_req   <= 1'b1;
                            mem_we    <= is_store;
                            mem_addr  <= {addr[31:2], 2'b00};
                            mem_wdata <= wrep_c;
                            mem_be    <= be_c;
                        end else begin
                            state <= RESP;
                            done  <= 1'b1;
                            err   <= 1'b1;
                        end
                    end
                end
                ACCESS: begin
                    if (mem_ack) begin
                        state   <= RESP;
                        done    <= 1'b1;
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                        if (!is_store_q) rdata <= ext_c;
                    end else if (TIMEOUT_CYCLES != 0 && tcnt == TIMEOUT_CYCLES - 1) begin
                        // This wait cycle is the TIMEOUT_CYCLES-th without ack.
                        state   <= RESP;
                        done    <= 1'b1;
                        err     <= 1'b1;
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                    end else begin
                        tcnt <= tcnt + 32'd1;
                    end
                end
                RESP: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: expected completions are queued at
// start and retired by a monitor on each done pulse.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        is_store = 1'b0;
    logic [2:0]  funct3 = '0;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic        busy, done, err;
    logic [31:0] rdata;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = '0;

    load_store_unit #(.TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .rst(rst), .start(start), .is_store(is_store),
        .funct3(funct3), .addr(addr), .wdata(wdata),
        .busy(busy), .done(done), .err(err), .rdata(rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_be(mem_be),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int unsigned n_vec = 0;
    int unsigned n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    typedef struct {
        logic        err;
        logic [31:0] rdata;
        int unsigned lat;
        int unsigned t0;
    } exp_t;

    exp_t exp_q[$];

    always @(negedge clk) begin
        if (rst && done) begin
            if (exp_q.size() == 0) begin
                check("spurious_done", {31'd0, done}, 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("err", {31'd0, err}, {31'd0, e.err});
                check("rdata", rdata, e.rdata);
                check("latency", cyc - e.t0, e.lat);
                check("busy_at_done", {31'd0, busy}, 32'd1);
            end
        end
    end

    // ebe == 0 marks a request expected to be rejected without bus activity;
    // ack_dly < 0 means never acknowledge (timeout path).
    task automatic do_access(input logic st, input logic [2:0] f3,
                             input logic [31:0] a, input logic [31:0] wd,
                             input logic [31:0] rword, input int ack_dly,
                             input logic [3:0] ebe, input logic [31:0] ewd,
                             input logic eerr, input logic [31:0] erd,
                             input int unsigned elat);
        int hold;
        int i;
        @(negedge clk);
        exp_q.push_back('{eerr, erd, elat, cyc});
        start = 1'b1; is_store = st; funct3 = f3; addr = a; wdata = wd;
        @(negedge clk);
        start = 1'b0;
        if (ebe != 4'b0000) begin
            check("req", {31'd0, mem_req}, 32'd1);
            check("we", {31'd0, mem_we}, {31'd0, st});
            check("be", {28'd0, mem_be}, {28'd0, ebe});
            check("maddr", mem_addr, {a[31:2], 2'b00});
            check("mwdata", mem_wdata, ewd);
            hold = (ack_dly < 0) ? 3 : ack_dly;
            for (int k = 0; k < hold; k++) begin
                @(negedge clk);
                check("req_hold", {31'd0, mem_req}, 32'd1);
            end
            if (ack_dly >= 0) begin
                mem_ack = 1'b1; mem_rdata = rword;
                @(negedge clk);
                mem_ack = 1'b0; mem_rdata = '0;
            end
        end else begin
            check("no_req", {31'd0, mem_req}, 32'd0);
            // A legal start presented during the response cycle must be dropped.
            start = 1'b1; is_store = 1'b0; funct3 = 3'b010; addr = 32'h0;
            @(negedge clk);
            start = 1'b0;
            check("resp_start_busy", {31'd0, busy}, 32'd0);
            check("resp_start_req", {31'd0, mem_req}, 32'd0);
        end
        for (i = 0; i < 16 && exp_q.size() != 0; i++) @(negedge clk);
        check("done_seen", exp_q.size(), 32'd0);
        exp_q.delete();
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_err", {31'd0, err}, 32'd0);
        check("rst_req", {31'd0, mem_req}, 32'd0);
        check("rst_we", {31'd0, mem_we}, 32'd0);
        check("rst_be", {28'd0, mem_be}, 32'd0);
        check("rst_rdata", rdata, 32'd0);
        check("rst_maddr", mem_addr, 32'd0);
        check("rst_mwdata", mem_wdata, 32'd0);
        rst = 1'b1;

        //        st    f3      addr          wdata         rword         dly be       ewd           err   erd           lat
        do_access(1'b1, 3'b010, 32'h0000_1008, 32'hDEAD_BEEF, 32'h0,        0, 4'b1111, 32'hDEAD_BEEF, 1'b0, 32'h0,        2);
        do_access(1'b0, 3'b000, 32'h0000_0203, 32'h0,        32'h80FF_0000, 3, 4'b1000, 32'h0,        1'b0, 32'hFFFF_FF80, 5);
        do_access(1'b0, 3'b100, 32'h0000_0203, 32'h0,        32'h80FF_0000, 0, 4'b1000, 32'h0,        1'b0, 32'h0000_0080, 2);
        do_access(1'b1, 3'b001, 32'h0000_0102, 32'h1234_ABCD, 32'h0,        0, 4'b1100, 32'hABCD_ABCD, 1'b0, 32'h0000_0080, 2);
        do_access(1'b0, 3'b101, 32'h0000_0102, 32'h0,        32'h9876_0000, 0, 4'b1100, 32'h0,        1'b0, 32'h0000_9876, 2);
        do_access(1'b0, 3'b001, 32'h0000_0101, 32'h0,        32'h0,        0, 4'b0000, 32'h0,        1'b1, 32'h0000_9876, 1);
        do_access(1'b0, 3'b010, 32'h0000_0101, 32'h0,        32'h0,        0, 4'b0000, 32'h0,        1'b1, 32'h0000_9876, 1);
        do_access(1'b1, 3'b011, 32'h0000_0000, 32'h0,        32'h0,        0, 4'b0000, 32'h0,        1'b1, 32'h0000_9876, 1);
        do_access(1'b0, 3'b010, 32'h0000_0040, 32'h0,        32'h0,       -1, 4'b1111, 32'h0,        1'b1, 32'h0000_9876, 5);

        // Late ack after the timeout must not disturb the idle unit.
        mem_ack = 1'b1; mem_rdata = 32'hFFFF_FFFF;
        @(negedge clk);
        mem_ack = 1'b0; mem_rdata = '0;
        check("late_ack_busy", {31'd0, busy}, 32'd0);
        check("late_ack_req", {31'd0, mem_req}, 32'd0);
        check("late_ack_rdata", rdata, 32'h0000_9876);

        // Reset in the middle of an access.
        @(negedge clk);
        start = 1'b1; is_store = 1'b0; funct3 = 3'b010; addr = 32'h80; wdata = '0;
        @(negedge clk);
        start = 1'b0;
        check("pre_rst_req", {31'd0, mem_req}, 32'd1);
        #2 rst = 1'b0;
        #1;
        check("mid_rst_req", {31'd0, mem_req}, 32'd0);
        check("mid_rst_busy", {31'd0, busy}, 32'd0);
        repeat (2) @(negedge clk);
        check("mid_rst_done", {31'd0, done}, 32'd0);
        rst = 1'b1;
        do_access(1'b0, 3'b010, 32'h0000_0010, 32'h0, 32'hCAFE_F00D, 0, 4'b1111, 32'h0, 1'b0, 32'hCAFE_F00D, 2);

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
